// File: rtl/vsync_gen.sv
// Vertical timing for the VGA path: line counter, vsync, scan window and frame strobe.
// Define VSYNC_FRAME_CNT_EN to build the free-running frame counter on frame_cnt.
module vsync_gen #(
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter bit          SYNC_POL  = 1'b0,
  parameter int unsigned FRAME_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               p_tick,
  input  logic               h_end,
  output logic [9:0]         pixel_y,
  output logic               v_end,
  output logic               vsync,
  output logic               v_scan_on,
  output logic               frame_tick,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  typedef enum logic [1:0] {StActive, StFront, StSync, StBack} state_e;

  state_e     state_q;
  logic       line_adv;
  logic       wrap;
  logic [9:0] y_next;

  assign line_adv = p_tick & h_end;
  assign wrap     = (pixel_y == 10'(V_TOTAL - 1));
  assign y_next   = wrap ? 10'd0 : pixel_y + 10'd1;
  assign v_end    = wrap;

  // State, vsync and v_scan_on all switch on the same edge as pixel_y so they never disagree.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StActive;
      pixel_y    <= '0;
      vsync      <= ~SYNC_POL;
      v_scan_on  <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (line_adv) begin
        pixel_y    <= y_next;
        frame_tick <= wrap;
        unique case (state_q)
          StActive: begin
            if (y_next == 10'(V_DISPLAY)) begin
              state_q   <= StFront;
              v_scan_on <= 1'b0;
            end
          end
          StFront: begin
            if (y_next == 10'(V_DISPLAY + V_FRONT)) begin
              state_q <= StSync;
              vsync   <= SYNC_POL;
            end
          end
          StSync: begin
            if (y_next == 10'(V_DISPLAY + V_FRONT + V_SYNC)) begin
              state_q <= StBack;
              vsync   <= ~SYNC_POL;
            end
          end
          StBack: begin
            if (wrap) begin
              state_q   <= StActive;
              v_scan_on <= 1'b1;
            end
          end
        endcase
      end
    end
  end

`ifdef VSYNC_FRAME_CNT_EN
  logic [FRAME_W-1:0] frame_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt_q <= '0;
    end else if (line_adv && wrap) begin
      frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: doc/vsync_gen.md
Name: vsync_gen

Overview:
- Vertical timing stage of the VGA pong display path, directly downstream of the horizontal sync counter.
- Consumes that counter's end-of-line strobe, qualified by the pixel tick.
- Produces the vertical line coordinate, vertical sync, vertical scan window and frame strobes.
- Outputs feed the pixel/object generator and the top-level VGA pins alongside hsync.

Parameters:
V_DISPLAY, 480, visible lines
V_FRONT, 10, front-porch lines
V_SYNC, 2, sync-pulse lines
V_BACK, 33, back-porch lines
SYNC_POL, 0, asserted level of vsync (0 = active-low)
FRAME_W, 8, width of optional frame counter

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
p_tick  input  1  pixel-rate enable
h_end  input  1  last pixel of line, from horizontal counter
pixel_y  output  10  current line, 0..V_TOTAL-1
v_end  output  1  high while pixel_y == V_TOTAL-1
vsync  output  1  vertical sync, registered
v_scan_on  output  1  high while in ACTIVE state (pixel_y < V_DISPLAY)
frame_tick  output  1  one-clk pulse on frame wrap
frame_cnt  output  FRAME_W  frame count (optional feature)

Behaviour:
- V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (default 525); pixel_y must be 10 bits wide enough for V_TOTAL-1.
- line_adv = p_tick & h_end. This is the only event that changes the counter or state. p_tick alone or h_end alone: no change.
- Counter, on each line_adv:
  - pixel_y <= (pixel_y == V_TOTAL-1) ? 0 : pixel_y+1.
- FSM states, advanced on the line_adv where pixel_y+1 crosses each boundary:
  - ACTIVE: 0..V_DISPLAY-1
  - FRONT: V_DISPLAY..V_DISPLAY+V_FRONT-1
  - SYNC: next V_SYNC lines
  - BACK: remaining lines to V_TOTAL-1
  - Transitions: ACTIVE->FRONT->SYNC->BACK->ACTIVE on wrap. State and pixel_y must always agree.
- vsync:
  - Registered; equals SYNC_POL in the same clock that state==SYNC.
  - Equals ~SYNC_POL otherwise.
  - Defaults: low on lines 490-491, high elsewhere.
- v_scan_on: registered alongside state; 1 iff state==ACTIVE.
- v_end: combinational decode of registered pixel_y.
- frame_tick:
  - Registered; high for exactly one clk, the cycle after the line_adv that wraps pixel_y to 0.
  - Low otherwise, including during stalls.
- Reset (reset==0, asynchronous, any time including mid-frame):
  - pixel_y=0, state=ACTIVE, vsync=~SYNC_POL, v_scan_on=1, frame_tick=0, frame_cnt=0.
  - v_end=0 follows from pixel_y=0.
- Reset release: counting resumes at the first line_adv.
- Back-to-back line_adv on consecutive clocks is legal; each advances one line.
- Latency: line_adv on clk edge N; pixel_y, state, vsync and v_scan_on reflect the new line after edge N; frame_tick after edge N.

Optional Feature:
- Macro VSYNC_FRAME_CNT_EN.
- Defined: frame_cnt increments by 1 on each frame wrap, in the same edge frame_tick is set. Wraps modulo 2^FRAME_W. Cleared by reset.
- Undefined: frame_cnt is tied to 0 and no counter register is synthesized. All other behaviour is identical.

Test Plan:
- Reset held 0 with p_tick=1, h_end=1 toggling -> pixel_y=0, vsync=1, v_scan_on=1, frame_tick=0, no counting.
- p_tick=1, h_end pulsed 480 times -> pixel_y=480, v_scan_on=0, vsync=1. After 490 pulses: vsync=0. After 492 pulses: vsync=1.
- h_end=1 with p_tick=0 for 100 clks -> pixel_y unchanged.
- Drive 524 line_adv -> v_end=1. Next line_adv -> pixel_y=0, v_end=0, v_scan_on=1, frame_tick=1 for exactly one clk.
- Assert reset=0 mid-sync at pixel_y=491 -> outputs return to reset values immediately, without waiting for a clock edge.
- VSYNC_FRAME_CNT_EN defined, 256 full frames -> frame_cnt 0..255 then wraps to 0. Undefined: frame_cnt stays 0.
